// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if -- bundle of the requester and memory-side signals
// of the fetch/data memory port arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives
//            grants, completions, memory command/address/data, stall).
//   master : environment view (requesters plus memory model).
interface memory_port_arbiter_if;
  // fetch requester
  logic        Fetch_Req;
  logic [31:0] Fetch_Addr;
  logic        Fetch_Grant;
  logic        Fetch_Done;
  logic [31:0] Fetch_Data;
  // data (memory-stage) requester
  logic        Data_Req;
  logic [1:0]  Data_Cmd;
  logic [31:0] Data_Addr;
  logic [31:0] Data_Wdata;
  logic        Data_Grant;
  logic        Data_Done;
  logic [31:0] Data_Rdata;
  // memory side
  logic [1:0]  MEM_r_w_z_z;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_Wdata;
  logic [31:0] MEM_Rdata;
  logic        MEM_Ready;
  // pipeline control
  logic        MA_Select;
  logic        Stall;
  logic        Timeout_Error;

  modport slave (
    input  Fetch_Req, Fetch_Addr,
    output Fetch_Grant, Fetch_Done, Fetch_Data,
    input  Data_Req, Data_Cmd, Data_Addr, Data_Wdata,
    output Data_Grant, Data_Done, Data_Rdata,
    output MEM_r_w_z_z, MEM_Addr, MEM_Wdata,
    input  MEM_Rdata, MEM_Ready,
    output MA_Select, Stall, Timeout_Error
  );

  modport master (
    output Fetch_Req, Fetch_Addr,
    input  Fetch_Grant, Fetch_Done, Fetch_Data,
    output Data_Req, Data_Cmd, Data_Addr, Data_Wdata,
    input  Data_Grant, Data_Done, Data_Rdata,
    input  MEM_r_w_z_z, MEM_Addr, MEM_Wdata,
    output MEM_Rdata, MEM_Ready,
    input  MA_Select, Stall, Timeout_Error
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter -- shares one memory port between the instruction
// fetch and the memory-stage data requester. One access in flight at most;
// ties are broken round-robin. An access that waits WAIT_LIMIT edges for
// MEM_Ready parks the arbiter in a sticky ERROR state until reset.
// Ports:
//   Clock   : sole clock, rising edge.
//   Reset_n : asynchronous active-low reset.
//   bus     : memory_port_arbiter_if.slave (requests, grants, completions,
//             memory command/address/data, MA_Select, Stall, Timeout_Error).
module memory_port_arbiter #(
  parameter int WAIT_LIMIT = 15   // 1..255
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  memory_port_arbiter_if.slave  bus
);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [7:0] LIMIT     = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_ERROR} state_t;

  state_t      state, state_nxt;
  logic        cmd_ok;
  logic        fetch_elig, data_elig;
  logic        grant_f, grant_d;
  logic        ready_hit, timeout_hit;
  logic        last_data;   // 1: data was granted last, so fetch wins a tie
  logic [7:0]  wait_cnt;

  // A requester whose Done pulse is high this cycle is still holding Req
  // only because it has not yet seen the pulse; it must not be re-granted.
  assign cmd_ok     = (bus.Data_Cmd == CMD_READ) || (bus.Data_Cmd == CMD_WRITE);
  assign fetch_elig = bus.Fetch_Req && !bus.Fetch_Done;
  assign data_elig  = bus.Data_Req && !bus.Data_Done && cmd_ok;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_f     = 1'b0;
    grant_d     = 1'b0;
    ready_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (data_elig && (!fetch_elig || !last_data)) begin
          grant_d   = 1'b1;
          state_nxt = S_DATA;
        end else if (fetch_elig) begin
          grant_f   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH, S_DATA: begin
        if (bus.MEM_Ready) begin
          ready_hit = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt + 8'd1 == LIMIT) begin
          // this edge would be the WAIT_LIMIT-th wait edge
          timeout_hit = 1'b1;
          state_nxt   = S_ERROR;
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.Fetch_Grant <= 1'b0;
      bus.Fetch_Done  <= 1'b0;
      bus.Fetch_Data  <= '0;
      bus.Data_Grant  <= 1'b0;
      bus.Data_Done   <= 1'b0;
      bus.Data_Rdata  <= '0;
      bus.MEM_r_w_z_z <= CMD_IDLE;
      bus.MEM_Addr    <= '0;
      bus.MEM_Wdata   <= '0;
      bus.MA_Select   <= 1'b0;
      wait_cnt        <= '0;
      last_data       <= 1'b0;
    end else begin
      // grant and done are single-cycle pulses
      bus.Fetch_Grant <= grant_f;
      bus.Data_Grant  <= grant_d;
      bus.Fetch_Done  <= ready_hit && (state == S_FETCH);
      bus.Data_Done   <= ready_hit && (state == S_DATA);

      // Access parameters are frozen at the grant edge so the requester
      // may change its inputs freely while the access is in flight.
      if (grant_d) begin
        bus.MEM_r_w_z_z <= bus.Data_Cmd;
        bus.MEM_Addr    <= bus.Data_Addr;
        bus.MEM_Wdata   <= bus.Data_Wdata;
        bus.MA_Select   <= 1'b1;
        last_data       <= 1'b1;
      end else if (grant_f) begin
        bus.MEM_r_w_z_z <= CMD_READ;
        bus.MEM_Addr    <= bus.Fetch_Addr;
        bus.MEM_Wdata   <= '0;
        bus.MA_Select   <= 1'b0;
        last_data       <= 1'b0;
      end else if (ready_hit || timeout_hit) begin
        // MA_Select and address are left alone: they hold through IDLE
        bus.MEM_r_w_z_z <= CMD_IDLE;
      end

      if (ready_hit && (state == S_FETCH))
        bus.Fetch_Data <= bus.MEM_Rdata;
      if (ready_hit && (state == S_DATA) && (bus.MEM_r_w_z_z == CMD_READ))
        bus.Data_Rdata <= bus.MEM_Rdata;

      if (grant_f || grant_d)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_DATA) && !bus.MEM_Ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held,
  // even if a requester is already asserting.
  assign bus.Stall = Reset_n &&
                     ((state != S_IDLE) || fetch_elig || data_elig);
  assign bus.Timeout_Error = (state == S_ERROR);

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
  logic Clock;
  logic Reset_n;
  int   n_chk;
  int   n_pass;

  memory_port_arbiter_if bus();

  memory_port_arbiter #(.WAIT_LIMIT(15)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    Reset_n        = 1'b0;
    bus.Fetch_Req  = 1'b0;
    bus.Fetch_Addr = '0;
    bus.Data_Req   = 1'b0;
    bus.Data_Cmd   = 2'b00;
    bus.Data_Addr  = '0;
    bus.Data_Wdata = '0;
    bus.MEM_Rdata  = '0;
    bus.MEM_Ready  = 1'b0;
    #2;
    // reset state
    chk("rst_fgrant", bus.Fetch_Grant, 0);
    chk("rst_cmd", bus.MEM_r_w_z_z, 0);
    chk("rst_stall", bus.Stall, 0);
    chk("rst_tmo", bus.Timeout_Error, 0);
    chk("rst_fdata", bus.Fetch_Data, 0);
    tick();
    tick();

    // single fetch, minimum latency
    Reset_n = 1'b1;
    bus.Fetch_Req  = 1'b1;
    bus.Fetch_Addr = 32'h100;
    #1;
    chk("t1_stall_elig", bus.Stall, 1);
    tick();
    chk("t1_fgrant", bus.Fetch_Grant, 1);
    chk("t1_cmd", bus.MEM_r_w_z_z, 2'b10);
    chk("t1_addr", bus.MEM_Addr, 32'h100);
    chk("t1_masel", bus.MA_Select, 0);
    chk("t1_fdone_early", bus.Fetch_Done, 0);
    bus.Fetch_Addr = 32'h999;
    bus.MEM_Ready  = 1'b1;
    bus.MEM_Rdata  = 32'hDEADBEEF;
    tick();
    chk("t1_fdone", bus.Fetch_Done, 1);
    chk("t1_fdata", bus.Fetch_Data, 32'hDEADBEEF);
    chk("t1_cmd_idle", bus.MEM_r_w_z_z, 0);
    chk("t1_fgrant_pulse", bus.Fetch_Grant, 0);
    bus.Fetch_Req = 1'b0;
    bus.MEM_Ready = 1'b0;
    tick();
    chk("t1_fdone_pulse", bus.Fetch_Done, 0);
    chk("t1_stall_idle", bus.Stall, 0);
    chk("t1_masel_hold", bus.MA_Select, 0);

    // both held across reset: data wins the first tie
    Reset_n = 1'b0;
    bus.Fetch_Req  = 1'b1;
    bus.Fetch_Addr = 32'h200;
    bus.Data_Req   = 1'b1;
    bus.Data_Cmd   = 2'b01;
    bus.Data_Addr  = 32'h20;
    bus.Data_Wdata = 32'h55;
    #1;
    chk("t2_rst_stall", bus.Stall, 0);
    chk("t2_rst_fdata", bus.Fetch_Data, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("t2_dgrant", bus.Data_Grant, 1);
    chk("t2_fgrant_no", bus.Fetch_Grant, 0);
    chk("t2_cmd_wr", bus.MEM_r_w_z_z, 2'b01);
    chk("t2_wdata", bus.MEM_Wdata, 32'h55);
    chk("t2_addr", bus.MEM_Addr, 32'h20);
    chk("t2_masel", bus.MA_Select, 1);
    bus.MEM_Ready = 1'b1;
    bus.MEM_Rdata = 32'h12345678;
    tick();
    chk("t2_ddone", bus.Data_Done, 1);
    chk("t2_rdata_wr", bus.Data_Rdata, 0);
    bus.Data_Req  = 1'b0;
    bus.MEM_Ready = 1'b0;
    tick();
    chk("t2_fgrant", bus.Fetch_Grant, 1);
    chk("t2_cmd_rd", bus.MEM_r_w_z_z, 2'b10);
    chk("t2_masel_f", bus.MA_Select, 0);
    chk("t2_addr_f", bus.MEM_Addr, 32'h200);
    bus.MEM_Ready = 1'b1;
    bus.MEM_Rdata = 32'hCAFEF00D;
    tick();
    chk("t2_fdone", bus.Fetch_Done, 1);
    chk("t2_fdata", bus.Fetch_Data, 32'hCAFEF00D);
    chk("t2_rdata_hold", bus.Data_Rdata, 0);

    // continuous requests alternate D,F,D,F
    bus.MEM_Ready  = 1'b0;
    bus.Fetch_Req  = 1'b1;
    bus.Fetch_Addr = 32'h300;
    bus.Data_Req   = 1'b1;
    bus.Data_Cmd   = 2'b10;
    bus.Data_Addr  = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_dgrant%0d", i), bus.Data_Grant, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_fgrant%0d", i), bus.Fetch_Grant, (i % 2 == 1) ? 1 : 0);
      bus.MEM_Ready = 1'b1;
      bus.MEM_Rdata = 32'h1000_00A0 + i;
      tick();
      if (i % 2 == 0) begin
        chk($sformatf("t3_ddone%0d", i), bus.Data_Done, 1);
        chk($sformatf("t3_rdata%0d", i), bus.Data_Rdata, 32'h1000_00A0 + i);
      end else begin
        chk($sformatf("t3_fdone%0d", i), bus.Fetch_Done, 1);
        chk($sformatf("t3_fdata%0d", i), bus.Fetch_Data, 32'h1000_00A0 + i);
      end
      bus.MEM_Ready = 1'b0;
      if (i == 3) begin
        bus.Fetch_Req = 1'b0;
        bus.Data_Req  = 1'b0;
      end
    end
    tick();
    chk("t3_stall_end", bus.Stall, 0);
    chk("t3_no_dgrant", bus.Data_Grant, 0);

    // timeout: read waits forever
    bus.Data_Req  = 1'b1;
    bus.Data_Cmd  = 2'b10;
    bus.Data_Addr = 32'h80;
    tick();
    chk("t4_dgrant", bus.Data_Grant, 1);
    bus.Data_Addr = 32'hFFF0;
    for (int i = 0; i < 14; i++) tick();
    chk("t4_cmd_wait", bus.MEM_r_w_z_z, 2'b10);
    chk("t4_tmo_early", bus.Timeout_Error, 0);
    chk("t4_addr_latched", bus.MEM_Addr, 32'h80);
    tick();
    chk("t4_tmo", bus.Timeout_Error, 1);
    chk("t4_stall", bus.Stall, 1);
    chk("t4_cmd_err", bus.MEM_r_w_z_z, 0);
    chk("t4_no_done", bus.Data_Done, 0);
    bus.MEM_Ready = 1'b1;
    bus.MEM_Rdata = 32'hBAD;
    tick();
    chk("t4_ign_done", bus.Data_Done, 0);
    chk("t4_ign_rdata", bus.Data_Rdata, 32'h1000_00A2);
    chk("t4_tmo_sticky", bus.Timeout_Error, 1);
    chk("t4_no_grant", bus.Data_Grant, 0);

    // reset mid-access, then an invalid command
    Reset_n = 1'b0;
    bus.Data_Req  = 1'b0;
    bus.MEM_Ready = 1'b0;
    tick();
    Reset_n = 1'b1;
    bus.Data_Req  = 1'b1;
    bus.Data_Cmd  = 2'b10;
    bus.Data_Addr = 32'h44;
    tick();
    chk("t5_dgrant", bus.Data_Grant, 1);
    tick();
    tick();
    Reset_n = 1'b0;
    #1;
    chk("t5_rst_cmd", bus.MEM_r_w_z_z, 0);
    chk("t5_rst_masel", bus.MA_Select, 0);
    chk("t5_rst_stall", bus.Stall, 0);
    chk("t5_rst_addr", bus.MEM_Addr, 0);
    chk("t5_rst_rdata", bus.Data_Rdata, 0);
    chk("t5_rst_tmo", bus.Timeout_Error, 0);
    bus.MEM_Ready = 1'b1;
    tick();
    chk("t5_no_done", bus.Data_Done, 0);
    Reset_n = 1'b1;
    bus.MEM_Ready = 1'b0;
    bus.Data_Cmd  = 2'b11;
    #1;
    chk("t5_inv_stall", bus.Stall, 0);
    tick();
    chk("t5_inv_grant0", bus.Data_Grant, 0);
    tick();
    chk("t5_inv_grant1", bus.Data_Grant, 0);
    chk("t5_inv_cmd", bus.MEM_r_w_z_z, 0);
    chk("t5_inv_stall2", bus.Stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
